// File: rtl/axis_fork_dispatch.sv
// AXI4-Stream 1-to-M_COUNT fork: round-robin per packet or broadcast per beat, job-based.
// Optional per-channel output beat counters when AXIS_FORK_DISPATCH_STATS_EN is defined.
module axis_fork_dispatch #(
    parameter int M_COUNT       = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fork_enable,
    input  logic                          fork_mode,
    input  logic [M_COUNT-1:0]            chan_mask,
    input  logic [PKT_CNT_WIDTH-1:0]      pkt_count,
    output logic                          fork_busy,
    output logic                          fork_done,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_COUNT-1:0]            m_axis_tlast,
    output logic [M_COUNT-1:0]            m_axis_tvalid,
`ifdef AXIS_FORK_DISPATCH_STATS_EN
    output logic [M_COUNT*32-1:0]         stat_beats,
`endif
    input  logic [M_COUNT-1:0]            m_axis_tready
);

    localparam int PTR_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_reg;
    logic                     mode_reg;
    logic [M_COUNT-1:0]       mask_reg;
    logic [PKT_CNT_WIDTH-1:0] cnt_reg;
    logic [PTR_W-1:0]         rr_ptr_reg;
    logic [M_COUNT-1:0]       pending_reg;
    logic [DATA_WIDTH-1:0]    tdata_reg;
    logic                     tlast_reg;
    logic                     done_reg;

    logic [M_COUNT-1:0]       pending_left;
    logic [M_COUNT-1:0]       rr_onehot;
    logic [PTR_W-1:0]         rr_next;
    logic [PTR_W-1:0]         rr_first;
    logic                     in_fire;
    logic                     job_start;

    // Channels still owing acceptance after this cycle's handshakes.
    assign pending_left  = pending_reg & ~m_axis_tready;
    assign s_axis_tready = (state_reg == RUN) && (pending_left == '0);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign job_start     = (state_reg == IDLE) && fork_enable && (chan_mask != '0);

    // Next enabled channel above the pointer, wrapping; falls back to itself for a single-bit mask.
    always_comb begin
        int cand;
        cand    = 0;
        rr_next = rr_ptr_reg;
        for (int i = M_COUNT; i >= 1; i--) begin
            cand = (int'(rr_ptr_reg) + i) % M_COUNT;
            if (mask_reg[PTR_W'(cand)]) rr_next = PTR_W'(cand);
        end
    end

    always_comb begin
        rr_first = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (chan_mask[PTR_W'(i)]) rr_first = PTR_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mode_reg    <= 1'b0;
            mask_reg    <= '0;
            cnt_reg     <= '0;
            rr_ptr_reg  <= '0;
            pending_reg <= '0;
            tdata_reg   <= '0;
            tlast_reg   <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            pending_reg <= pending_left;
            if (in_fire) begin
                pending_reg <= mode_reg ? mask_reg : rr_onehot;
                tdata_reg   <= s_axis_tdata;
                tlast_reg   <= s_axis_tlast;
            end
            case (state_reg)
                IDLE: begin
                    if (job_start) begin
                        mode_reg   <= fork_mode;
                        mask_reg   <= chan_mask;
                        cnt_reg    <= (pkt_count == '0) ? PKT_CNT_WIDTH'(1) : pkt_count;
                        rr_ptr_reg <= rr_first;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (in_fire && s_axis_tlast) begin
                        cnt_reg <= cnt_reg - PKT_CNT_WIDTH'(1);
                        if (!mode_reg) rr_ptr_reg <= rr_next;
                        if (cnt_reg == PKT_CNT_WIDTH'(1)) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pending_left == '0) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_chan
            assign rr_onehot[gi]                               = (rr_ptr_reg == PTR_W'(gi));
            assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH]   = tdata_reg;
            assign m_axis_tlast[gi]                            = tlast_reg & pending_reg[gi];
        end
    endgenerate

    assign m_axis_tvalid = pending_reg;
    assign fork_busy     = (state_reg == RUN);
    assign fork_done     = done_reg;

`ifdef AXIS_FORK_DISPATCH_STATS_EN
    generate
        for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_stat
            logic [31:0] beat_cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || job_start) begin
                    beat_cnt_reg <= '0;
                end else if (pending_reg[gi] && m_axis_tready[gi] && (beat_cnt_reg != 32'hFFFF_FFFF)) begin
                    beat_cnt_reg <= beat_cnt_reg + 32'd1;
                end
            end
            assign stat_beats[gi*32 +: 32] = beat_cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_axis_fork_dispatch.sv
// Bench for axis_fork_dispatch: per-channel expected-beat queues built from the job rules,
// plus directed timing/handshake checks.
module tb_axis_fork_dispatch;
    localparam int M  = 4;
    localparam int DW = 64;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fork_enable;
    logic          fork_mode;
    logic [M-1:0]  chan_mask;
    logic [PW-1:0] pkt_count;
    logic          fork_busy;
    logic          fork_done;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [M*DW-1:0] m_tdata;
    logic [M-1:0]  m_tlast;
    logic [M-1:0]  m_tvalid;
    logic [M-1:0]  m_ready;
`ifdef AXIS_FORK_DISPATCH_STATS_EN
    logic [M*32-1:0] stat_beats;
`endif

    always #5 clk = ~clk;

    axis_fork_dispatch #(.M_COUNT(M), .DATA_WIDTH(DW), .PKT_CNT_WIDTH(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fork_enable   (fork_enable),
        .fork_mode     (fork_mode),
        .chan_mask     (chan_mask),
        .pkt_count     (pkt_count),
        .fork_busy     (fork_busy),
        .fork_done     (fork_done),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
`ifdef AXIS_FORK_DISPATCH_STATS_EN
        .stat_beats    (stat_beats),
`endif
        .m_axis_tready (m_ready)
    );

    int checks = 0;
    int errors = 0;

    // Model state: expected {data,last} per channel, job parameters, bookkeeping.
    logic [DW:0]  exp_q [M][$];
    int           en_list[$];
    logic         mdl_active = 1'b0;
    logic         mdl_mode = 1'b0;
    int           pkt_idx = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           last_acc_cyc = 0;
    int           first_fire_cyc = 0;
    int           fires = 0;
    int           acc_cnt [M];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic compare_loop();
        logic [DW:0] exp;
        int ch;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                for (int c = 0; c < M; c++) exp_q[c].delete();
                mdl_active = 1'b0;
            end else begin
                if (fork_done) begin
                    done_cnt++;
                    done_cyc   = cyc;
                    mdl_active = 1'b0;
                end
                for (int c = 0; c < M; c++) begin
                    if (m_tvalid[c] && m_ready[c]) begin
                        checks++;
                        acc_cnt[c]++;
                        last_acc_cyc = cyc;
                        if (exp_q[c].size() == 0) begin
                            errors++;
                            $display("FAIL out_beat ch%0d: got %0h last %0b, required no beat", c,
                                     m_tdata[c*DW +: DW], m_tlast[c]);
                        end else begin
                            exp = exp_q[c].pop_front();
                            if ({m_tdata[c*DW +: DW], m_tlast[c]} !== exp) begin
                                errors++;
                                $display("FAIL out_beat ch%0d: got %0h last %0b, required %0h last %0b", c,
                                         m_tdata[c*DW +: DW], m_tlast[c], exp[DW:1], exp[0]);
                            end
                        end
                    end
                end
                if (s_tready && !mdl_active) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ready_idle: got s_tready 1, required 0");
                end
                if (!mdl_active && fork_enable && chan_mask != '0) begin
                    mdl_active = 1'b1;
                    mdl_mode   = fork_mode;
                    en_list.delete();
                    for (int c = 0; c < M; c++) if (chan_mask[c]) en_list.push_back(c);
                    pkt_idx = 0;
                    fires   = 0;
                end else if (s_tvalid && s_tready) begin
                    if (fires == 0) first_fire_cyc = cyc;
                    fires++;
                    if (mdl_mode) begin
                        foreach (en_list[k]) exp_q[en_list[k]].push_back({s_tdata, s_tlast});
                    end else begin
                        ch = en_list[pkt_idx % en_list.size()];
                        exp_q[ch].push_back({s_tdata, s_tlast});
                        if (s_tlast) pkt_idx++;
                    end
                end
            end
        end
    endtask

    task automatic start_job(input logic mode, input logic [M-1:0] mask, input int cnt);
        fork_enable = 1'b1;
        fork_mode   = mode;
        chan_mask   = mask;
        pkt_count   = PW'(cnt);
        @(posedge clk); #1;
        fork_enable = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tready && n < 200);
        chk("send_accept", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fork_done && n < 500);
        chk("done_seen", 64'(fork_done), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        int a [M];
        for (int c = 0; c < M; c++) acc_cnt[c] = 0;
        rst = 1'b1; fork_enable = 1'b0; fork_mode = 1'b0; chan_mask = '0; pkt_count = '0;
        s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_ready = 4'hF;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_busy", 64'(fork_busy), 64'd0);
        chk("rst_done", 64'(fork_done), 64'd0);
        @(posedge clk); #1;

        // Round-robin over 1011, four 2-beat packets: ch0, ch1, ch3, ch0
        d0 = done_cnt;
        for (int c = 0; c < M; c++) a[c] = acc_cnt[c];
        start_job(1'b0, 4'b1011, 4);
        chk("rr_busy", 64'(fork_busy), 64'd1);
        for (int i = 0; i < 8; i++) send_beat(64'h100 + 64'(i), (i % 2) == 1);
        s_tvalid = 1'b0;
        wait_done();
        chk("rr_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("rr_done_after_acc", 64'(done_cyc - last_acc_cyc), 64'd1);
        chk("rr_cycles", 64'(done_cyc - first_fire_cyc), 64'd9);
        chk("rr_ch0_beats", 64'(acc_cnt[0] - a[0]), 64'd4);
        chk("rr_ch1_beats", 64'(acc_cnt[1] - a[1]), 64'd2);
        chk("rr_ch2_beats", 64'(acc_cnt[2] - a[2]), 64'd0);
        chk("rr_ch3_beats", 64'(acc_cnt[3] - a[3]), 64'd2);
        @(negedge clk);
        chk("rr_done_one_cycle", 64'(fork_done), 64'd0);
        chk("rr_idle_busy", 64'(fork_busy), 64'd0);
        @(posedge clk); #1;

        // Broadcast 1111, ch2 stalls beat 0 for 5 cycles
        for (int c = 0; c < M; c++) a[c] = acc_cnt[c];
        m_ready = 4'b1011;
        start_job(1'b1, 4'b1111, 3);
        send_beat(64'hA5A5_A5A5_0000_0000, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 64'hA5A5_A5A5_0000_0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bc_stall_s_tready", 64'(s_tready), 64'd0);
            chk("bc_stall_tvalid", 64'(m_tvalid), (k == 0) ? 64'hF : 64'h4);
        end
        @(posedge clk); #1;
        m_ready = 4'hF;
        send_beat(64'hA5A5_A5A5_0000_0001, 1'b1);
        send_beat(64'hA5A5_A5A5_0000_0002, 1'b1);
        s_tvalid = 1'b0;
        wait_done();
        for (int c = 0; c < M; c++) chk($sformatf("bc_ch%0d_beats", c), 64'(acc_cnt[c] - a[c]), 64'd3);

        // Enable with empty mask is ignored
        d0 = done_cnt;
        start_job(1'b0, 4'b0000, 5);
        s_tvalid = 1'b1;
        s_tdata  = 64'hDEAD;
        s_tlast  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mask0_busy", 64'(fork_busy), 64'd0);
            chk("mask0_s_tready", 64'(s_tready), 64'd0);
        end
        #1 chk("mask0_no_done", 64'(done_cnt - d0), 64'd0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;

        // pkt_count 0 acts as 1 packet; goes to ch1 (lowest of 0110)
        d0 = done_cnt;
        for (int c = 0; c < M; c++) a[c] = acc_cnt[c];
        start_job(1'b0, 4'b0110, 0);
        send_beat(64'h500, 1'b0);
        send_beat(64'h501, 1'b1);
        s_tdata = 64'h502;
        s_tvalid = 1'b1;
        wait_done();
        @(negedge clk);
        chk("cnt0_s_tready", 64'(s_tready), 64'd0);
        #1;
        chk("cnt0_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("cnt0_ch1_beats", 64'(acc_cnt[1] - a[1]), 64'd2);
        chk("cnt0_ch2_beats", 64'(acc_cnt[2] - a[2]), 64'd0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;

        // Reset mid-packet, then a new job starts on the lowest masked channel
        m_ready = 4'h0;
        start_job(1'b0, 4'b1100, 3);
        send_beat(64'h600, 1'b0);
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_busy", 64'(fork_busy), 64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        m_ready = 4'hF;
        for (int c = 0; c < M; c++) a[c] = acc_cnt[c];
        start_job(1'b0, 4'b1100, 1);
        send_beat(64'h610, 1'b1);
        s_tvalid = 1'b0;
        wait_done();
        chk("postrst_ch2_beats", 64'(acc_cnt[2] - a[2]), 64'd1);
        chk("postrst_ch3_beats", 64'(acc_cnt[3] - a[3]), 64'd0);

`ifdef AXIS_FORK_DISPATCH_STATS_EN
        start_job(1'b1, 4'b0101, 10);
        for (int i = 0; i < 10; i++) send_beat(64'h700 + 64'(i), 1'b1);
        s_tvalid = 1'b0;
        wait_done();
        chk("stat_ch0", 64'(stat_beats[31:0]), 64'd10);
        chk("stat_ch1", 64'(stat_beats[63:32]), 64'd0);
        chk("stat_ch2", 64'(stat_beats[95:64]), 64'd10);
        chk("stat_ch3", 64'(stat_beats[127:96]), 64'd0);
        start_job(1'b1, 4'b0101, 1);
        @(negedge clk);
        chk("stat_clear", 64'(stat_beats != '0), 64'd0);
        @(posedge clk); #1;
        send_beat(64'h710, 1'b1);
        s_tvalid = 1'b0;
        wait_done();
`endif

        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < M; c++) chk($sformatf("q_empty_ch%0d", c), 64'(exp_q[c].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_fork_dispatch.md
Name: axis_fork_dispatch

Overview:
- Parametrised AXI4-Stream 1-to-M_COUNT fork for the datapath input stage; next generation of the fixed 4-port fork arbiter.
- Two modes: round-robin packet distribution over a runtime channel mask, or broadcast of every beat to all enabled outputs.
- Job-based: a job is started by fork_enable and completes after a programmed number of packets; fork_done then pulses.
- Single registered output stage: every output beat comes from a register, never combinationally from the input.

Parameters:
- M_COUNT, 4, number of output channels (2..16).
- DATA_WIDTH, 64, tdata width in bits.
- PKT_CNT_WIDTH, 16, width of the per-job packet count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fork_enable  in  1  job start; sampled only in IDLE.
- fork_mode  in  1  0 = round-robin per packet, 1 = broadcast; latched at job start.
- chan_mask  in  M_COUNT  enabled outputs; latched at job start.
- pkt_count  in  PKT_CNT_WIDTH  packets in the job; latched at job start; 0 is treated as 1.
- fork_busy  out  1  high in RUN.
- fork_done  out  1  one-cycle pulse at job completion.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  shared output register, replicated per channel.
- m_axis_tlast  out  M_COUNT  output last, per channel.
- m_axis_tvalid  out  M_COUNT  output valid, per channel.
- m_axis_tready  in  M_COUNT  output ready, per channel.

Behaviour:
- Reset values:
  - State IDLE.
  - s_axis_tready, m_axis_tvalid, m_axis_tlast, fork_busy and fork_done are 0.
  - Pending mask 0; round-robin pointer selects the lowest set bit of the next latched mask.
- FSM IDLE:
  - fork_enable=1 and chan_mask!=0: latch mode, mask and count, then go to RUN next cycle.
  - fork_enable=1 and chan_mask==0: ignored, stay in IDLE.
- FSM RUN:
  - Accepts beats until the pkt_count-th tlast beat is accepted, then goes to DRAIN.
- FSM DRAIN:
  - Waits for the pending mask to reach 0.
  - fork_done=1 for exactly one cycle, in the cycle the FSM returns to IDLE.
- Pending mask:
  - Holds the channels still owing acceptance of the registered beat.
  - m_axis_tvalid = pending mask.
  - A pending bit clears when that channel's tvalid and tready are both high.
- Input handshake:
  - s_axis_tready = RUN and (pending==0 or every pending bit accepted this cycle).
  - This gives full throughput (one beat per cycle) when the outputs are ready.
  - Input transfer = tvalid and tready, with a 1-cycle latency to output valid.
- Broadcast mode:
  - Loaded pending mask = latched chan_mask.
  - The next beat waits until all enabled channels have accepted the current one.
- Round-robin mode:
  - Loaded pending mask = one-hot rr_ptr.
  - rr_ptr advances after a tlast beat is accepted at the input, to the next set mask bit above the current one, wrapping to the lowest.
  - All beats of a packet go to the same channel.
- Packet counter:
  - Decrements on each accepted input tlast beat.
  - The beat that brings it to 0 ends RUN.
- Input outside RUN: s_axis_tready=0, so input is backpressured.
- fork_enable while busy: ignored; input changes do not alter the latched job parameters.
- Single-channel mask in round-robin mode: rr_ptr stays on that channel.
- Reset mid-job: next cycle is IDLE with all outputs at reset values; in-flight beats are discarded.

Optional Feature:
- Macro: AXIS_FORK_DISPATCH_STATS_EN.
- Defined:
  - Adds output port stat_beats, M_COUNT*32 bits: a per-channel count of accepted output beats.
  - Counters clear on rst and on job start, and saturate at 0xFFFFFFFF.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- RR, mask=4'b1011, pkt_count=4, 2-beat packets, all ready -> packets appear on ch0, ch1, ch3, ch0; fork_done pulses once, 1 cycle after the last output accept; 8 beats in 9 cycles.
- Broadcast, mask=4'b1111, 3 single-beat packets, ch2 tready held low for 5 cycles on beat 0 -> ch0/1/3 accept once (no duplicates); s_axis_tready stays 0 until ch2 accepts; data 0xA5.. arrives on all 4 channels in order.
- fork_enable with chan_mask=0 -> stays IDLE, fork_busy=0, no fork_done; s_axis_tready=0.
- pkt_count=0, RR mode -> exactly 1 packet is forwarded, then fork_done pulses.
- rst asserted mid-packet in RUN -> next cycle all m_axis_tvalid=0 and fork_busy=0; a new job then starts at the lowest masked channel.
- STATS_EN, broadcast with mask=4'b0101 and 10 beats -> stat_beats = {0,10,0,10} for channels {3,2,1,0}; cleared at the next job start.
